data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, single-port synchronous data memory with a valid/ready request interface and a fixed-latency read response pipeline.
- Includes a hardware clear engine that sweeps every word to INIT_VALUE after reset and on demand.
- Sits between the CPU load/store stage and the storage array. Replaces the combinational 8x256 data memory.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words.
- INIT_VALUE, 9, value written to every word by the clear engine (truncated to DATA_WIDTH).
- READ_LATENCY, 1, cycles from read acceptance to rsp_valid; legal values 1 or 2.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  request a full-memory clear; sampled in READY only.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid, one-cycle pulse.
- rsp_rdata  out  DATA_WIDTH  read data; holds its last value when rsp_valid=0.
- busy  out  1  clear engine active.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=CLEAR, clear counter=0.
  - rsp_valid=0, rsp_rdata=0, busy=1, req_ready=0.
  - Read pipeline valid bits cleared; in-flight reads are dropped.
  - Array contents are not reset directly.
- State machine, two states:
  - CLEAR: each cycle writes INIT_VALUE to array[counter], then increments counter. Takes exactly DEPTH cycles after rst_n deasserts. On the cycle counter==DEPTH-1 is written, go to READY and reset counter to 0.
  - READY: if clear_req=1, go to CLEAR next cycle. Otherwise serve requests.
- req_ready = (state==READY) && !clear_req. This is combinational, so clear_req has priority and no request is accepted in that cycle.
- busy = (state==CLEAR).
- Write accepted at edge N: array[req_addr] updated at edge N. A read accepted at N+1 to the same address returns the new data. No response is produced for a write.
- Read accepted at edge N: array is sampled at edge N.
  - READ_LATENCY=1: rsp_valid=1 and rsp_rdata valid in cycle N+1.
  - READ_LATENCY=2: data is registered once more; response appears in cycle N+2.
  - A write accepted after the read to the same address does not alter that read's data.
- Back-to-back reads: one accepted per cycle; responses are returned in order, one per cycle, with no bubbles.
- A clear started while reads are in flight does not cancel them. They complete with pre-clear data.
- Clear counter is ADDR_WIDTH+1 bits wide. No address wrap-around in the array; every req_addr is in range by construction.
- Reset asserted mid-clear or mid-read: the clear restarts from address 0 and pending responses are discarded.

Test Plan:
- Reset release, defaults -> busy=1 and req_ready=0 for exactly 256 cycles, then req_ready=1. Reads of addresses 0, 128, 255 return 8'h09 with rsp_valid one cycle after acceptance.
- Write 8'hA5 to addr 8'h10, then read 8'h10 the next cycle -> rsp_rdata=8'hA5 one cycle after the read. Read of 8'h11 -> 8'h09.
- READ_LATENCY=2: read addr 3, then write 8'h55 to addr 3 the next cycle -> the read response in cycle N+2 returns 8'h09. A following read returns 8'h55.
- Streaming reads of addrs 0..7 after writes of data=addr+1 -> eight consecutive rsp_valid cycles with data 1..8 in order.
- clear_req and req_valid in the same cycle after writing 8'hFF to addr 5 -> request not accepted (req_ready=0), busy=1 for 256 cycles, then read of addr 5 returns 8'h09.
- rst_n pulsed low at clear cycle 100 -> busy stays 1 for a full 256 cycles after release. No rsp_valid is produced for a read accepted before the reset.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port synchronous data memory with a valid/ready
// request port, a fixed-latency read response pipeline (1 or 2 cycles) and
// a clear engine that sweeps every word to INIT_VALUE after reset and on
// request. Sits between the CPU load/store stage and the storage array.
module data_memory_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int INIT_VALUE   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] INIT_WORD  = DATA_WIDTH'(INIT_VALUE);
    // The counter is one bit wider than the address so a full sweep never
    // relies on wrap-around to detect its last word.
    localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   clr_count;
    logic [ADDR_WIDTH:0]   clr_count_next;

    // Array write port, shared between the clear engine and CPU writes.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_accept;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // First read stage: array sampled on the accepting edge.
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // State register and clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            state     <= CLEAR;
            clr_count <= '0;
        end else begin
            state     <= state_next;
            clr_count <= clr_count_next;
        end
    end

    // Next-state logic, handshake outputs and array write-port steering.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next     = state;
        clr_count_next = clr_count;
        req_ready      = 1'b0;
        busy           = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = req_addr;
        mem_wdata      = req_wdata;
        rd_accept      = 1'b0;

        case (state)
            CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_count[ADDR_WIDTH-1:0];
                mem_wdata = INIT_WORD;
                if (clr_count == LAST_COUNT) begin
                    state_next     = READY;
                    clr_count_next = '0;
                end else begin
                    clr_count_next = clr_count + COUNT_ONE;
                end
            end

            READY: begin
                // clear_req wins over any request presented in the same cycle.
                req_ready = !clear_req;
                if (clear_req) begin
                    state_next     = CLEAR;
                    clr_count_next = '0;
                end else if (req_valid) begin
                    if (req_write) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_accept = 1'b1;
                    end
                end
            end

            default: begin
                state_next     = CLEAR;
                clr_count_next = '0;
            end
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; after reset the clear engine
        // initialises it word by word instead.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // First read stage: capture array data on acceptance, hold it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= mem[req_addr];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            // Second read stage: one extra register, data held between pulses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rsp_valid = s2_valid;
            assign rsp_rdata = s2_data;
        end else begin : g_lat1
            assign rsp_valid = s1_valid;
            assign rsp_rdata = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Testbench for data_memory_ctrl: one instance per read latency, fed by the
// same directed stimulus. A behavioural model (word array, clear countdown,
// queues of due responses) is compared against both instances after every
// clock edge; directed literal checks pin the model's expectations.
module tb_data_memory_ctrl;

    localparam int         DEPTH = 256;
    localparam logic [7:0] INIT  = 8'h09;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_req;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;

    logic       req_ready1, rsp_valid1, busy1;
    logic [7:0] rsp_rdata1;
    logic       req_ready2, rsp_valid2, busy2;
    logic [7:0] rsp_rdata2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (8),
        .INIT_VALUE  (9),
        .READ_LATENCY(1)
    ) dut_l1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_req(clear_req),
        .req_valid(req_valid),
        .req_ready(req_ready1),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1),
        .rsp_rdata(rsp_rdata1),
        .busy     (busy1)
    );

    data_memory_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (8),
        .INIT_VALUE  (9),
        .READ_LATENCY(2)
    ) dut_l2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_req(clear_req),
        .req_valid(req_valid),
        .req_ready(req_ready2),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2),
        .rsp_rdata(rsp_rdata2),
        .busy     (busy2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        logic [7:0] data;
    } rsp_t;

    logic [7:0] m_mem [DEPTH];
    int         m_busy_left;
    int         cyc = 0;
    rsp_t       q1[$];
    rsp_t       q2[$];
    logic [7:0] m_last1;
    logic [7:0] m_last2;

    task automatic model_reset();
        // After reset the clear sweep leaves every word at INIT before any
        // access can be accepted, so the model fills the array at once.
        foreach (m_mem[i]) m_mem[i] = INIT;
        m_busy_left = DEPTH;
        q1.delete();
        q2.delete();
        m_last1 = 8'h00;
        m_last2 = 8'h00;
    endtask

    // Model update on each edge, then compare both DUTs just after the edge.
    always @(posedge clk) begin
        logic exp_v1;
        logic exp_v2;
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (clear_req) begin
            m_busy_left = DEPTH;
            foreach (m_mem[i]) m_mem[i] = INIT;
        end else if (req_valid) begin
            if (req_write) begin
                m_mem[req_addr] = req_wdata;
            end else begin
                q1.push_back('{due: cyc,     data: m_mem[req_addr]});
                q2.push_back('{due: cyc + 1, data: m_mem[req_addr]});
            end
        end

        #1;
        exp_v1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (exp_v1) begin
            m_last1 = q1[0].data;
            void'(q1.pop_front());
        end
        exp_v2 = (q2.size() > 0) && (q2[0].due == cyc);
        if (exp_v2) begin
            m_last2 = q2[0].data;
            void'(q2.pop_front());
        end

        check("model_busy1",      busy1,      m_busy_left > 0);
        check("model_busy2",      busy2,      m_busy_left > 0);
        check("model_req_ready1", req_ready1, (m_busy_left == 0) && !clear_req);
        check("model_req_ready2", req_ready2, (m_busy_left == 0) && !clear_req);
        check("model_rsp_valid1", rsp_valid1, exp_v1);
        check("model_rsp_valid2", rsp_valid2, exp_v2);
        check("model_rsp_rdata1", rsp_rdata1, m_last1);
        check("model_rsp_rdata2", rsp_rdata2, m_last2);
    end

    // ------------------------------------------------------------------
    // Directed stimulus (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic drive_idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        clear_req = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
    endtask

    // Present one request for one cycle; returns on the next falling edge.
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        drive_idle();
    endtask

    // Single read; latency-1 response checked first, latency-2 one cycle later.
    task automatic read_check(input logic [7:0] a, input logic [7:0] exp, input string tag);
        issue(1'b0, a, 8'h00);
        check({tag, "_l1_valid"}, rsp_valid1, 1'b1);
        check({tag, "_l1_data"},  rsp_rdata1, exp);
        check({tag, "_l2_early"}, rsp_valid2, 1'b0);
        @(negedge clk);
        check({tag, "_l1_pulse"}, rsp_valid1, 1'b0);
        check({tag, "_l1_hold"},  rsp_rdata1, exp);
        check({tag, "_l2_valid"}, rsp_valid2, 1'b1);
        check({tag, "_l2_data"},  rsp_rdata2, exp);
    endtask

    // Count cycles with busy high (bounded), then expect the port ready.
    task automatic count_busy(input string tag);
        int n = 0;
        while (busy1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_cycles"}, n, 256);
        check({tag, "_ready1"}, req_ready1, 1'b1);
        check({tag, "_ready2"}, req_ready2, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_busy1",      busy1,      1'b1);
        check("rst_req_ready1", req_ready1, 1'b0);
        check("rst_rsp_valid1", rsp_valid1, 1'b0);
        check("rst_rsp_rdata1", rsp_rdata1, 8'h00);
        check("rst_rsp_valid2", rsp_valid2, 1'b0);
        check("rst_rsp_rdata2", rsp_rdata2, 8'h00);

        rst_n = 1'b1;
        count_busy("init");

        // Freshly cleared words.
        read_check(8'd0,   INIT, "rd0");
        read_check(8'd128, INIT, "rd128");
        read_check(8'd255, INIT, "rd255");

        // Write then read back; neighbour untouched.
        issue(1'b1, 8'h10, 8'hA5);
        read_check(8'h10, 8'hA5, "wr_a5");
        read_check(8'h11, INIT,  "rd11");

        // Read of addr 3 followed by a write to addr 3: the read keeps old data.
        issue(1'b0, 8'h03, 8'h00);
        check("rw3_l1_data", rsp_rdata1, INIT);
        issue(1'b1, 8'h03, 8'h55);
        check("rw3_l2_valid", rsp_valid2, 1'b1);
        check("rw3_l2_data",  rsp_rdata2, INIT);
        read_check(8'h03, 8'h55, "rd3_new");

        // Streaming reads of addrs 0..7 holding data addr+1.
        for (int i = 0; i < 8; i++) issue(1'b1, 8'(i), 8'(i + 1));
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 8'(i);
            @(negedge clk);
            check("stream_l1_valid", rsp_valid1, 1'b1);
            check("stream_l1_data",  rsp_rdata1, 8'(i + 1));
            if (i > 0) begin
                check("stream_l2_valid", rsp_valid2, 1'b1);
                check("stream_l2_data",  rsp_rdata2, 8'(i));
            end
        end
        drive_idle();
        @(negedge clk);
        check("stream_l1_end",  rsp_valid1, 1'b0);
        check("stream_l2_last", rsp_valid2, 1'b1);
        check("stream_l2_data8", rsp_rdata2, 8'h08);

        // clear_req collides with a request: request refused, memory cleared.
        issue(1'b1, 8'h05, 8'hFF);
        clear_req = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h05;
        req_wdata = 8'h77;
        #1;
        check("collide_ready1", req_ready1, 1'b0);
        check("collide_ready2", req_ready2, 1'b0);
        @(negedge clk);
        drive_idle();
        count_busy("clear");
        read_check(8'h05, INIT, "rd5_cleared");

        // Reset while a latency-2 read is in flight: its response is dropped.
        issue(1'b1, 8'h07, 8'h3C);
        issue(1'b0, 8'h07, 8'h00);
        check("rstrd_l1_valid", rsp_valid1, 1'b1);
        check("rstrd_l1_data",  rsp_rdata1, 8'h3C);
        rst_n = 1'b0;
        #1;
        check("rstrd_l1_async", rsp_valid1, 1'b0);
        check("rstrd_l2_async", rsp_valid2, 1'b0);
        @(negedge clk);
        check("rstrd_l2_dropped", rsp_valid2, 1'b0);
        rst_n = 1'b1;
        count_busy("rst_mid_read");
        read_check(8'h07, INIT, "rd7_after_rst");

        // Reset about 100 cycles into a clear: the sweep restarts from scratch.
        issue(1'b1, 8'h09, 8'hC3);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (100) @(negedge clk);
        check("midclr_busy", busy1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("rst_mid_clear");
        read_check(8'h09, INIT, "rd9_after_rst");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
